// File: rtl/led_pause_blinker_pkg.sv
// Shared types and helpers for the pause-indicator LED blinker.
// Holds the FSM state encoding and the half-period counter sizing.
package led_pause_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int HALF_PERIOD_DEFAULT = 12_500_000;

  // Width of a counter that must reach half_period-1.
  function automatic int half_cnt_width(input int half_period);
    return (half_period < 2) ? 1 : $clog2(half_period);
  endfunction

endpackage

// File: rtl/led_pause_blinker_if.sv
// Signal bundle between the pause PIO, the blinker and the board LED/debug taps.
// The master drives pause and brightness; the slave (the blinker) drives the rest.
interface led_pause_blinker_if #(
  parameter int DUTY_BITS = 4,
  parameter int CNT_BITS  = 8
);
  logic                 pause_in;
  logic [DUTY_BITS-1:0] brightness;
  logic                 led_out;
  logic                 paused_sync;
  logic                 blink_phase;
  logic [CNT_BITS-1:0]  blink_count;

  modport master (
    output pause_in, brightness,
    input  led_out, paused_sync, blink_phase, blink_count
  );

  modport slave (
    input  pause_in, brightness,
    output led_out, paused_sync, blink_phase, blink_count
  );
endinterface

// File: rtl/led_pause_blinker_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level.
// Reusable for any PIO-fed input; STAGES must be at least 2.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/led_pause_blinker.sv
// Turns the CPU pause level into an LED pattern: dark when running, PWM-dimmed
// blinking while paused, plus phase and saturating blink-count debug outputs.
module led_pause_blinker
  import led_pause_blinker_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,
  parameter int DUTY_BITS   = 4,
  parameter int CNT_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_pause_blinker_if.slave   bus
);

  localparam int                   HALF_W    = half_cnt_width(HALF_PERIOD);
  localparam logic [HALF_W-1:0]    HALF_LAST = HALF_W'(HALF_PERIOD - 1);
  localparam logic [DUTY_BITS-1:0] DUTY_FULL = '1;
  localparam logic [CNT_BITS-1:0]  CNT_MAX   = '1;

  logic                 sync_q;
  logic                 prev_sync;
  logic                 rise;
  logic                 terminal;
  state_e               state, next_state;
  logic [HALF_W-1:0]    half_cnt, next_half;
  logic [CNT_BITS-1:0]  next_count;
  logic [DUTY_BITS-1:0] pwm_cnt;
  logic                 led_next;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.pause_in),
    .q       (sync_q)
  );

  assign bus.paused_sync = sync_q;
  assign rise            = sync_q & ~prev_sync;
  assign terminal        = (half_cnt == HALF_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_state = state;
    next_half  = half_cnt + 1'b1;
    next_count = bus.blink_count;
    case (state)
      ST_IDLE: begin
        next_half = '0;
        if (rise) begin
          next_state = ST_ON;
          next_count = '0;
        end
      end
      ST_ON: begin
        // Release wins over a terminal count landing in the same cycle.
        if (!sync_q) begin
          next_state = ST_IDLE;
          next_half  = '0;
        end else if (terminal) begin
          next_state = ST_OFF;
          next_half  = '0;
          next_count = (bus.blink_count == CNT_MAX) ? bus.blink_count
                                                    : bus.blink_count + 1'b1;
        end
      end
      ST_OFF: begin
        if (!sync_q) begin
          next_state = ST_IDLE;
          next_half  = '0;
        end else if (terminal) begin
          next_state = ST_ON;
          next_half  = '0;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_half  = '0;
      end
    endcase
  end

  // Full brightness bypasses the compare so the ON phase has no PWM gap.
  assign led_next = (state == ST_ON) &&
                    ((pwm_cnt < bus.brightness) || (bus.brightness == DUTY_FULL));

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
    if (!reset_n) begin
      state           <= ST_IDLE;
      half_cnt        <= '0;
      prev_sync       <= 1'b0;
      pwm_cnt         <= '0;
      bus.blink_count <= '0;
      bus.led_out     <= 1'b0;
      bus.blink_phase <= 1'b0;
    end else begin
      state           <= next_state;
      half_cnt        <= next_half;
      prev_sync       <= sync_q;
      pwm_cnt         <= pwm_cnt + 1'b1;
      bus.blink_count <= next_count;
      bus.led_out     <= led_next;
      bus.blink_phase <= (next_state == ST_ON);
    end
  end

endmodule

// File: tb/tb_led_pause_blinker.sv
// Directed bench for led_pause_blinker with HALF_PERIOD=8, SYNC_STAGES=2;
// a second instance with a 2-bit blink counter shares the same stimulus.
module tb_led_pause_blinker;

  logic clk;
  logic reset_n;
  int   k;
  int   n_assert;
  int   n_fail;

  led_pause_blinker_if #(.DUTY_BITS(4), .CNT_BITS(8)) mif ();
  led_pause_blinker_if #(.DUTY_BITS(4), .CNT_BITS(2)) sif ();

  assign sif.pause_in   = mif.pause_in;
  assign sif.brightness = mif.brightness;

  led_pause_blinker #(
    .SYNC_STAGES(2), .HALF_PERIOD(8), .DUTY_BITS(4), .CNT_BITS(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif.slave)
  );

  led_pause_blinker #(
    .SYNC_STAGES(2), .HALF_PERIOD(8), .DUTY_BITS(4), .CNT_BITS(2)
  ) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
      end
  endtask

  // Expected pattern when state entered ON at edge 'base' (edges counted from reset release).
  function automatic bit on_exp(input int kk, input int base);
    return (kk >= base) && (((kk - base) % 16) < 8);
  endfunction

  // led_out after edge kk reflects state and pwm count (== kk mod 16) before that edge.
  function automatic bit led_exp(input int kk, input int base, input int b);
    return on_exp(kk - 1, base) && (((kk % 16) < b) || (b == 15));
  endfunction

  function automatic int cnt_exp(input int kk, input int base, input int maxv);
    int c;
    c = (kk < base + 8) ? 0 : ((kk - base - 8) / 16 + 1);
    return (c > maxv) ? maxv : c;
  endfunction

  task automatic check_pattern(input int base, input logic ps);
    check("blink_phase", 32'(mif.blink_phase), 32'(on_exp(k, base)));
    check("led_out", 32'(mif.led_out), 32'(led_exp(k, base, int'(mif.brightness))));
    check("blink_count", 32'(mif.blink_count), 32'(cnt_exp(k, base, 255)));
    check("sat_count", 32'(sif.blink_count), 32'(cnt_exp(k, base, 3)));
    check("paused_sync", 32'(mif.paused_sync), 32'(ps));
  endtask

  task automatic check_fixed(input string tag, input logic led, input logic ph,
                             input int cnt, input int scnt, input logic ps);
    check({tag, "_led"}, 32'(mif.led_out), 32'(led));
    check({tag, "_phase"}, 32'(mif.blink_phase), 32'(ph));
    check({tag, "_count"}, 32'(mif.blink_count), 32'(cnt));
    check({tag, "_sat_count"}, 32'(sif.blink_count), 32'(scnt));
    check({tag, "_psync"}, 32'(mif.paused_sync), 32'(ps));
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    k              = 0;
    reset_n        = 1'b0;
    mif.pause_in   = 1'b1;
    mif.brightness = 4'd15;

    // Reset held with pause high: everything dark.
    repeat (3) tick();
    check_fixed("reset", 1'b0, 1'b0, 0, 0, 1'b0);
    reset_n = 1'b1;
    k       = -1;

    // Entry latency and full-brightness square wave; pause drops so that the
    // synchronised level falls exactly when ON reaches its terminal count.
    for (int i = 0; i <= 57; i++) begin
      tick();
      check_pattern(2, (k >= 1) && (k <= 56));
      if (k == 55) mif.pause_in = 1'b0;
    end
    tick();
    check_fixed("drop_terminal", 1'b1, 1'b0, 3, 3, 1'b0);
    for (int i = 59; i <= 74; i++) begin
      tick();
      check_fixed("idle_hold", 1'b0, 1'b0, 3, 3, 1'b0);
    end

    // Re-entry with PWM: ON windows see pwm 14,15,0..5.
    mif.pause_in   = 1'b1;
    mif.brightness = 4'd4;
    for (int i = 75; i <= 76; i++) begin
      tick();
      check_fixed("reentry_sync", 1'b0, 1'b0, 3, 3, (k == 76));
    end
    for (int i = 77; i <= 152; i++) begin
      tick();
      check_pattern(77, 1'b1);
      if (k == 85)  mif.brightness = 4'd0;
      if (k == 101) mif.brightness = 4'd15;
    end

    // Reset pulse in the middle of an OFF phase.
    reset_n = 1'b0;
    #1;
    check_fixed("reset_mid", 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    check_fixed("reset_mid_edge", 1'b0, 1'b0, 0, 0, 1'b0);
    reset_n = 1'b1;
    k       = -1;
    for (int i = 0; i <= 20; i++) begin
      tick();
      check_pattern(2, k >= 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pause_blinker.md
Name: led_pause_blinker

Overview:
- Downstream consumer of the 1-bit pause-indicator PIO output, which is a level written by the CPU.
- Converts the pause level into a visible LED pattern: LED dark while running; LED blinks at a fixed rate while paused, with brightness set by PWM during the on-phase.
- Sits between the PIO out_port and the board LED pin.
- Also reports the blink phase and a saturating blink count for debug.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on pause_in; minimum 2.
- HALF_PERIOD, 12_500_000: clk cycles per blink half-period (2 Hz at 50 MHz); minimum 2.
- DUTY_BITS, 4: width of the PWM counter and of the brightness input.
- CNT_BITS, 8: width of blink_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- pause_in  in  1  pause level from the PIO output; may be asynchronous
- brightness  in  DUTY_BITS  on-phase PWM duty; sampled every cycle
- led_out  out  1  registered LED drive, active-high
- paused_sync  out  1  synchronised pause level
- blink_phase  out  1  1 during the ON phase
- blink_count  out  CNT_BITS  completed ON→OFF transitions since pause entry; saturating

Behaviour:
- Reset (asynchronous, reset_n low): all sync flops, state, half-period counter, PWM counter and blink_count go to 0. Outputs at reset: led_out=0, paused_sync=0, blink_phase=0, blink_count=0.
- Synchroniser: a SYNC_STAGES-deep flop chain; the last stage drives paused_sync. A prev_sync flop supplies edge detection.
- State machine (2-bit encoding; the unused code recovers to IDLE):
  - IDLE: led off. A rising edge of paused_sync moves to ON, with half counter=0 and blink_count=0.
  - ON: at half counter==HALF_PERIOD-1, go to OFF and clear the counter; blink_count increments, saturating at all-ones.
  - OFF: at half counter==HALF_PERIOD-1, go to ON and clear the counter.
  - From ON or OFF: paused_sync==0 forces IDLE on the next edge, overriding a terminal count in the same cycle. Counter clears; blink_count holds its value until the next pause entry.
- PWM counter: free-running DUTY_BITS wide, wraps from all-ones to 0, never stalls.
- led_out next-value rule:
  - In ON: (pwm_cnt < brightness) OR (brightness == all-ones).
  - Otherwise: 0.
  - brightness=0 gives dark ON phases. brightness=all-ones gives solid on with no PWM gaps.
- blink_phase = (state==ON), registered with the state.
- Latency: if pause_in is high at edge 0, paused_sync goes high after edge SYNC_STAGES-1, state goes to ON after edge SYNC_STAGES, and led_out first reflects ON after edge SYNC_STAGES+1. Release has the same latency to led_out=0.
- Glitches on pause_in shorter than one clk period may be missed; this is acceptable.
- A pause re-entry while in IDLE restarts the pattern from the start of ON. blink_count clears on that entry.
- brightness changes mid-phase take effect on the next cycle; the PWM counter is not reset.
- Reset asserted mid-blink returns immediately to IDLE with led_out=0. After release, pause must be re-detected as a new rising edge: a pause_in held high through reset re-enters ON SYNC_STAGES edges after release.

Decomposition:
- Shared package: state enum (IDLE=0, ON=1, OFF=2) and a localparam for the half-counter width, $clog2(HALF_PERIOD).
- One natural sub-module: bit_synchronizer (parameter STAGES; ports clk, reset_n, d, q), reusable for other PIO-fed inputs.
- FSM, counters and PWM compare live in the top module.

Test Plan (HALF_PERIOD=8, SYNC_STAGES=2, DUTY_BITS=4):
1. Reset with pause_in=1 held → all outputs 0 during reset. After release, blink_phase goes to 1 two edges later, and led_out goes to 1 on the following edge with brightness=15.
2. pause_in=1 for 40 cycles with brightness=15 → led_out forms a square wave, 8 cycles high and 8 cycles low; blink_count reads 2 after 32 cycles in pattern and reaches 3 at the third ON→OFF transition.
3. brightness=4, paused, ON phase checked over 16 cycles → led_out high exactly where pwm_cnt is 0..3. brightness=0 → led_out stays 0 for all cycles.
4. pause_in dropped in the same cycle the synchronised level makes ON hit its terminal count → next state is IDLE, not OFF; led_out=0 three edges after the drop; blink_count holds its value.
5. Force blink_count saturation with CNT_BITS=2 over 5 blinks → blink_count sticks at 3. Re-entering pause clears it to 0.
6. Reset pulsed for 1 cycle mid-OFF-phase → immediate IDLE and led_out=0. The pattern restarts at ON with counter 0 after resynchronisation.
